// File: rtl/isp_pad_pkg.sv
// Shared types and default geometry for the frame border padder.
package isp_pad_pkg;

  typedef enum logic [2:0] {TOP, LEFT, BODY, RIGHT, BOTTOM} pad_state_t;

  localparam int WIDTH_DEFAULT  = 320;
  localparam int HEIGHT_DEFAULT = 240;
  localparam int PAD_W          = WIDTH_DEFAULT + 2;
  localparam int PAD_H          = HEIGHT_DEFAULT + 2;
  localparam int COL_BITS       = $clog2(PAD_W);
  localparam int ROW_BITS       = $clog2(PAD_H);

endpackage

// File: rtl/pad_pos_counter.sv
// Column/row position of the next padded beat; advances once per output load.
module pad_pos_counter
  import isp_pad_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int HEIGHT = HEIGHT_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          advance,
  output logic [$clog2(WIDTH+2)-1:0]    col,
  output logic [$clog2(HEIGHT+2)-1:0]   row,
  output logic                          last_col,
  output logic                          last_row,
  output logic                          sof
);

  localparam int CB = $clog2(WIDTH + 2);
  localparam int RB = $clog2(HEIGHT + 2);
  localparam logic [CB-1:0] COL_MAX = CB'(WIDTH + 1);
  localparam logic [RB-1:0] ROW_MAX = RB'(HEIGHT + 1);

  logic [CB-1:0] col_q, col_d;
  logic [RB-1:0] row_q, row_d;

  assign col      = col_q;
  assign row      = row_q;
  assign last_col = (col_q == COL_MAX);
  assign last_row = (row_q == ROW_MAX);
  assign sof      = (col_q == '0) && (row_q == '0);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (advance) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/frame_padder.sv
// Wraps a WIDTH x HEIGHT pixel stream in a one-pixel border.
// Define PADDER_EDGE_REPLICATE_EN to replicate edge pixels into the left/right border.
module frame_padder
  import isp_pad_pkg::*;
#(
  parameter int            WIDTH     = WIDTH_DEFAULT,
  parameter int            HEIGHT    = HEIGHT_DEFAULT,
  parameter int            DW        = 32,
  parameter logic [DW-1:0] PAD_VALUE = '0
) (
  input  logic          d5m_clk,
  input  logic          reset,
  input  logic [DW-1:0] iData,
  input  logic          iValid,
  output logic          iReady,
  output logic [DW-1:0] oData,
  output logic          oValid,
  input  logic          oReady,
  output logic          oSof,
  output logic          oEol,
  output logic          frame_done
);

  localparam int CB = $clog2(WIDTH + 2);
  localparam int RB = $clog2(HEIGHT + 2);
  localparam logic [CB-1:0] BODY_LAST_COL = CB'(WIDTH);
  localparam logic [RB-1:0] BODY_LAST_ROW = RB'(HEIGHT);

  pad_state_t    state_q, state_d;
  logic          ovalid_q, ovalid_d;
  logic [DW-1:0] odata_q, odata_d;
  logic          osof_q, osof_d;
  logic          oeol_q, oeol_d;
  logic          olast_q, olast_d;
  logic          done_q, done_d;

  logic          load_en, load, in_ready;
  logic [DW-1:0] beat_data;
  logic [CB-1:0] col;
  logic [RB-1:0] row;
  logic          last_col, last_row, sof;

`ifdef PADDER_EDGE_REPLICATE_EN
  logic [DW-1:0] hold_q, hold_d;
`endif

  pad_pos_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_pos (
    .clk      (d5m_clk),
    .rst      (reset),
    .advance  (load),
    .col      (col),
    .row      (row),
    .last_col (last_col),
    .last_row (last_row),
    .sof      (sof)
  );

  assign iReady     = in_ready;
  assign oData      = odata_q;
  assign oValid     = ovalid_q;
  assign oSof       = osof_q;
  assign oEol       = oeol_q;
  assign frame_done = done_q;

  always_comb begin
    load_en   = !ovalid_q || oReady;
    load      = 1'b0;
    in_ready  = 1'b0;
    beat_data = PAD_VALUE;
    state_d   = state_q;
    case (state_q)
      TOP: begin
        load = load_en;
        if (load && last_col) state_d = LEFT;
      end
      LEFT: begin
`ifdef PADDER_EDGE_REPLICATE_EN
        // Peek at the first pixel of the row; it stays upstream until BODY takes it.
        load      = load_en && iValid;
        beat_data = iData;
`else
        load      = load_en;
`endif
        if (load) state_d = BODY;
      end
      BODY: begin
        in_ready  = load_en;
        load      = iValid && load_en;
        beat_data = iData;
        if (load && (col == BODY_LAST_COL)) state_d = RIGHT;
      end
      RIGHT: begin
        load = load_en;
`ifdef PADDER_EDGE_REPLICATE_EN
        beat_data = hold_q;
`endif
        if (load) state_d = (row == BODY_LAST_ROW) ? BOTTOM : LEFT;
      end
      BOTTOM: begin
        load = load_en;
        if (load && last_col) state_d = TOP;
      end
      default: state_d = TOP;
    endcase
  end

  always_comb begin
    ovalid_d = ovalid_q;
    odata_d  = odata_q;
    osof_d   = osof_q;
    oeol_d   = oeol_q;
    olast_d  = olast_q;
    if (load) begin
      ovalid_d = 1'b1;
      odata_d  = beat_data;
      osof_d   = sof;
      oeol_d   = last_col;
      olast_d  = last_col && last_row;
    end else if (oReady) begin
      ovalid_d = 1'b0;
    end
    // Pulse once the final bottom-right beat leaves the output register.
    done_d = ovalid_q && oReady && olast_q;
  end

  always_ff @(posedge d5m_clk or posedge reset) begin
    if (reset) begin
      state_q  <= TOP;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
      osof_q   <= 1'b0;
      oeol_q   <= 1'b0;
      olast_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
      osof_q   <= osof_d;
      oeol_q   <= oeol_d;
      olast_q  <= olast_d;
      done_q   <= done_d;
    end
  end

`ifdef PADDER_EDGE_REPLICATE_EN
  assign hold_d = (state_q == BODY && load) ? iData : hold_q;

  always_ff @(posedge d5m_clk or posedge reset) begin
    if (reset) hold_q <= '0;
    else       hold_q <= hold_d;
  end
`endif

endmodule

// File: tb/tb_frame_padder.sv
// Directed bench for frame_padder: 4x3 frames under several flow patterns plus one full 320x240 frame.
module tb_frame_padder;

  localparam int W = 4;
  localparam int H = 3;
  localparam int BEATS = (W + 2) * (H + 2);
  localparam logic [31:0] PAD = 32'hFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_data;
  logic        i_valid, i_ready;
  logic [31:0] o_data;
  logic        o_valid, o_ready, o_sof, o_eol, frame_done;

  logic        b_rst;
  logic [31:0] b_idata, b_odata;
  logic        b_ivalid, b_iready, b_ovalid, b_oready, b_osof, b_oeol, b_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rec_data[$];
  logic        rec_sof[$];
  logic        rec_eol[$];

  int b_beats = 0, b_eol = 0, b_gap = 0;
  logic b_fin = 1'b0, b_sof_seen = 1'b0;

  always #5 clk = ~clk;

  frame_padder #(.WIDTH(W), .HEIGHT(H), .DW(32), .PAD_VALUE(PAD)) u_dut (
    .d5m_clk(clk), .reset(rst), .iData(i_data), .iValid(i_valid), .iReady(i_ready),
    .oData(o_data), .oValid(o_valid), .oReady(o_ready), .oSof(o_sof), .oEol(o_eol),
    .frame_done(frame_done)
  );

  frame_padder u_big (
    .d5m_clk(clk), .reset(b_rst), .iData(b_idata), .iValid(b_ivalid), .iReady(b_iready),
    .oData(b_odata), .oValid(b_ovalid), .oReady(b_oready), .oSof(b_osof), .oEol(b_oeol),
    .frame_done(b_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int f, input int r, input int c);
    int base;
    base = f * W * H + (r - 1) * W;
    if (r == 0 || r == H + 1) return PAD;
`ifdef PADDER_EDGE_REPLICATE_EN
    if (c == 0)     return 32'(base + 1);
    if (c == W + 1) return 32'(base + W);
`else
    if (c == 0 || c == W + 1) return PAD;
`endif
    return 32'(base + c);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    i_valid = 1'b0;
    o_ready = 1'b0;
    #1;
    check("rst_ovalid", 32'(o_valid), 32'd0);
    check("rst_odata", o_data, 32'd0);
    check("rst_osof", 32'(o_sof), 32'd0);
    check("rst_oeol", 32'(o_eol), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_iready", 32'(i_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ready_mode 0: oReady held high; 1: oReady alternates 1,0,1,0.
  task automatic run_frames(input int nframes, input int ready_mode, input int gap, input int abort_at);
    int idx, gap_cnt, beats, cyc, fd, target, f, p;
    logic prev_stall, prev_eol;
    logic [31:0] prev_data;
    idx = 1; gap_cnt = 0; beats = 0; cyc = 0; fd = 0;
    prev_stall = 1'b0; prev_eol = 1'b0; prev_data = '0;
    target = (abort_at > 0) ? abort_at : nframes * BEATS;
    rec_data.delete(); rec_sof.delete(); rec_eol.delete();
    while (beats < target && cyc < 4000) begin
      @(negedge clk);
      o_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      if (gap_cnt > 0) begin
        i_valid = 1'b0;
        gap_cnt--;
      end else if (idx <= nframes * W * H) begin
        i_valid = 1'b1;
        i_data  = 32'(idx);
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        check("stall_data", o_data, prev_data);
        check("stall_eol", 32'(o_eol), 32'(prev_eol));
      end
      if (o_valid && !o_ready) check("iready_in_stall", 32'(i_ready), 32'd0);
      if (frame_done) fd++;
      if (o_valid && o_ready) begin
        rec_data.push_back(o_data);
        rec_sof.push_back(o_sof);
        rec_eol.push_back(o_eol);
        beats++;
      end
      if (i_valid && i_ready) begin
        idx++;
        gap_cnt = gap;
      end
      prev_stall = o_valid && !o_ready;
      prev_data  = o_data;
      prev_eol   = o_eol;
      cyc++;
    end
    check("beat_count", 32'(beats), 32'(target));
    if (abort_at == 0) begin
      repeat (3) begin
        @(negedge clk);
        o_ready = 1'b1;
        i_valid = 1'b0;
        #1;
        if (frame_done) fd++;
      end
      check("frame_done_cnt", 32'(fd), 32'(nframes));
    end
    for (int k = 0; k < beats; k++) begin
      f = k / BEATS;
      p = k % BEATS;
      check($sformatf("data[%0d]", k), rec_data[k], exp_data(f, p / (W + 2), p % (W + 2)));
      check($sformatf("sof[%0d]", k), 32'(rec_sof[k]), 32'(p == 0));
      check($sformatf("eol[%0d]", k), 32'(rec_eol[k]), 32'((p % (W + 2)) == W + 1));
    end
  endtask

  always @(negedge clk) begin
    if (!b_rst && !b_fin) begin
      if (b_done) b_fin = 1'b1;
      else if (b_ovalid) begin
        b_beats++;
        if (b_oeol) b_eol++;
      end
    end
    if (b_fin && !b_sof_seen) begin
      if (b_ovalid && b_osof) b_sof_seen = 1'b1;
      else b_gap++;
    end
  end

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_data = '0; o_ready = 1'b0;
    b_rst = 1'b1; b_ivalid = 1'b1; b_idata = 32'h5A; b_oready = 1'b1;
    repeat (2) @(negedge clk);
    b_rst = 1'b0;

    do_reset(); run_frames(1, 0, 0, 0);
    do_reset(); run_frames(1, 1, 0, 0);
    do_reset(); run_frames(1, 0, 3, 0);
    do_reset(); run_frames(1, 0, 0, 15);
    do_reset(); run_frames(2, 0, 0, 0);

    for (int i = 0; i < 90000 && !(b_fin && b_sof_seen); i++) @(negedge clk);
    check("big_beats", 32'(b_beats), 32'd77924);
    check("big_eol", 32'(b_eol), 32'd242);
    check("big_sof_gap_le2", 32'(b_sof_seen && (b_gap <= 2)), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
